ball_steer_ctrl: RTL and testbench
==================================

// Module: ball_steer_ctrl
// PURPOSE
//  Closed-loop PD steering controller upstream of the 2-D rolling integrator. It consumes the integrator's
//  integer-mm ball position and goal flag each simulation tick. It produces the Q-format X/Y force words
//  that drive the integrator toward the origin. A start/hold/timeout state machine frames each episode and
//  reports completion.
// PARAMETERS
//  FRAC          12     Q fractional bits of force outputs (must match integrator)
//  KP            64     proportional gain, unsigned Q8 (64 = 0.25)
//  KD            256    derivative gain, unsigned Q8 (256 = 1.0)
//  F_MAX_Q       65536  force saturation magnitude, Q-format (16.0)
//  HOLD_TICKS    16     consecutive in-goal ticks required to declare done
//  TIMEOUT_TICKS 4096   episode tick budget before fault
// PORTS
//  clk            in   1   clock
//  rst_n          in   1   asynchronous, active-low reset
//  clk_en         in   1   simulation tick enable (same strobe as integrator)
//  start_i        in   1   begin episode; sampled on clk_en ticks in IDLE only
//  abort_i        in   1   immediate abort; acts on any clk edge
//  pos_mm_x_i     in   16  signed ball X position, mm
//  pos_mm_y_i     in   16  signed ball Y position, mm
//  goal_reached_i in   1   integrator goal flag
//  force_x_q_o    out  24  signed X force, Q(FRAC)
//  force_y_q_o    out  24  signed Y force, Q(FRAC)
//  busy_o         out  1   high in RUN or HOLD
//  done_o         out  1   one-clk pulse on successful hold
//  timeout_o      out  1   one-clk pulse on tick budget exhaustion
//  tick_cnt_o     out  16  ticks elapsed in current/last episode
//  state_o        out  3   encoded FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, err_prev 0, hold counter 0.
//  States: IDLE, RUN, HOLD, DONE, FAULT. All transitions occur on clk_en ticks except abort and reset.
//  IDLE : forces 0. On start_i=1 at a clk_en tick -> RUN; clear tick_cnt and hold counter; set first_tick.
//  RUN  : each tick: err = -pos (17b signed), derr = err - err_prev. On first_tick, derr is forced 0
//         (no derivative kick). f = (KP*err + KD*derr) <<< (FRAC-8), computed at 40b, saturated to
//         +/-F_MAX_Q, registered to force_*_q_o. err_prev <= err. Latency is 1 tick, pos -> force.
//         goal_reached_i=1 -> HOLD with hold counter = 1.
//  HOLD : PD keeps running. goal_reached_i=1 increments the hold counter. goal_reached_i=0 -> RUN and
//         clears the counter. Counter reaching HOLD_TICKS -> DONE.
//  DONE : forces 0; done_o high for exactly one clk; next clk -> IDLE (no clk_en needed).
//  FAULT: entered when tick_cnt reaches TIMEOUT_TICKS in RUN/HOLD. Forces 0; timeout_o high for one clk;
//         next clk -> IDLE.
//  tick_cnt increments on every clk_en in RUN/HOLD and saturates at 16'hFFFF. It holds its value in IDLE
//  until the next start.
//  Priority: reset > abort > done > timeout > goal/hold logic. If done and timeout fall on the same tick,
//  done wins.
//  abort_i=1: next clk state IDLE, forces 0, no done/timeout pulse, regardless of clk_en.
//  start_i while busy or in DONE/FAULT is ignored. Outputs hold between clk_en ticks.
//  KP, KD and F_MAX_Q are unsigned. F_MAX_Q must be <= 2^23-1. Saturation is symmetric.
// STRUCTURE
//  phys_pkg (shared): FRAC constant, q24_t/mm16_t typedefs, steer_state_e enum.
//  Sub-module pd_axis: err/derr, multiply-accumulate, shift and saturate for one axis, with its own
//  err_prev register and first_tick/enable inputs. Instantiated twice (X, Y).
//  The top holds the FSM, counters and pulse generation.
// TESTING
//  1 start, pos=(-10,0), held one tick -> next tick force_x=10240 (0x002800), force_y=0, busy=1.
//  2 pos x -10 then -8 -> second force_x = 64*8 + 256*(-2) = 0, shifted -> 0 (derivative cancels).
//  3 pos=(300,-300) -> force_x=-65536, force_y=+65536 (saturated).
//  4 goal_reached=1 for 16 ticks -> done_o one-clk pulse, forces 0, state IDLE.
//  4b goal drop at hold tick 10 -> back to RUN, counter cleared.
//  5 TIMEOUT_TICKS=32, goal never reached -> timeout_o pulse after tick 32, tick_cnt_o=32, IDLE.
//  6 abort mid-RUN with clk_en=0 -> IDLE and forces 0 next clk, no pulses.
//  6b start during RUN ignored.
//  6c rst_n low mid-HOLD -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/ball_steer_ctrl_pkg.sv
// ball_steer_ctrl_pkg: shared fixed-point types, default Q scaling and steering FSM state encoding.
package ball_steer_ctrl_pkg;
  localparam int FRAC_DEF = 12;
  typedef logic signed [23:0] q24_t;
  typedef logic signed [15:0] mm16_t;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_HOLD  = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } steer_state_e;
endpackage

// File: rtl/ball_steer_ctrl_pd_axis.sv
// ball_steer_ctrl_pd_axis: one-axis PD law driving position to 0, with a 40b accumulate and a symmetric
// saturating registered force output.
module ball_steer_ctrl_pd_axis import ball_steer_ctrl_pkg::*; #(
  parameter int FRAC    = FRAC_DEF,
  parameter int KP      = 64,
  parameter int KD      = 256,
  parameter int F_MAX_Q = 65536
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en_i,
  input  logic  first_i,
  input  logic  clr_i,
  input  mm16_t pos_i,
  output q24_t  force_o
);
  localparam logic signed [39:0] KP_S  = 40'(KP);
  localparam logic signed [39:0] KD_S  = 40'(KD);
  localparam logic signed [39:0] FMAX_S = 40'(F_MAX_Q);
  logic signed [16:0] err, err_prev_q;
  logic signed [17:0] derr;
  logic signed [39:0] acc, f;
  q24_t force_q, force_d;
  assign err = -17'(pos_i);
  // first tick after start has no valid history, so suppress the derivative kick
  assign derr = first_i ? '0 : 18'(err) - 18'(err_prev_q);
  assign acc = KP_S * 40'(err) + KD_S * 40'(derr);
  assign f = acc <<< (FRAC - 8);
  assign force_d = q24_t'(f > FMAX_S ? FMAX_S : (f < -FMAX_S ? -FMAX_S : f));
  assign force_o = force_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      force_q    <= '0;
      err_prev_q <= '0;
    end else if (clr_i) begin
      force_q <= '0;
    end else if (en_i) begin
      force_q    <= force_d;
      err_prev_q <= err;
    end
endmodule

// File: rtl/ball_steer_ctrl.sv
// ball_steer_ctrl: episode FSM (idle/run/hold/done/fault) around two PD axes steering the ball to the
// origin, with hold-to-done and tick-budget timeout.
module ball_steer_ctrl import ball_steer_ctrl_pkg::*; #(
  parameter int FRAC          = FRAC_DEF,
  parameter int KP            = 64,
  parameter int KD            = 256,
  parameter int F_MAX_Q       = 65536,
  parameter int HOLD_TICKS    = 16,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [15:0] pos_mm_x_i,
  input  logic [15:0] pos_mm_y_i,
  input  logic        goal_reached_i,
  output logic [23:0] force_x_q_o,
  output logic [23:0] force_y_q_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic [15:0] tick_cnt_o,
  output logic [2:0]  state_o
);
  localparam logic [15:0] HOLD_W = 16'(HOLD_TICKS);
  localparam logic [15:0] TO_W   = 16'(TIMEOUT_TICKS);
  steer_state_e state_q, state_d;
  logic [15:0] tick_q, tick_d, hold_q, hold_d, tick_inc, hold_inc;
  logic first_q, first_d, done_q, done_d, to_q, to_d, active, pd_en, pd_clr;
  q24_t fx, fy;
  assign active   = state_q inside {S_RUN, S_HOLD};
  assign tick_inc = &tick_q ? tick_q : tick_q + 16'd1;
  assign hold_inc = hold_q + 16'd1;
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    hold_d  = hold_q;
    first_d = first_q;
    done_d  = 1'b0;
    to_d    = 1'b0;
    if (abort_i) state_d = S_IDLE;
    else case (state_q)
      S_IDLE: if (clk_en && start_i) begin
        state_d = S_RUN;
        tick_d  = '0;
        hold_d  = '0;
        first_d = 1'b1;
      end
      S_RUN, S_HOLD: if (clk_en) begin
        tick_d  = tick_inc;
        first_d = 1'b0;
        hold_d  = goal_reached_i ? hold_inc : '0;
        state_d = goal_reached_i ? S_HOLD : S_RUN;
        // done outranks timeout when both land on the same tick
        if (goal_reached_i && hold_inc >= HOLD_W) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (tick_inc >= TO_W) begin
          state_d = S_FAULT;
          to_d    = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign pd_en  = clk_en & active & ~abort_i;
  assign pd_clr = !(state_d inside {S_RUN, S_HOLD});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      hold_q  <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      first_q <= first_d;
      done_q  <= done_d;
      to_q    <= to_d;
    end
  ball_steer_ctrl_pd_axis #(.FRAC(FRAC), .KP(KP), .KD(KD), .F_MAX_Q(F_MAX_Q)) u_pd_x (
    .clk(clk), .rst_n(rst_n), .en_i(pd_en), .first_i(first_q), .clr_i(pd_clr),
    .pos_i(mm16_t'(pos_mm_x_i)), .force_o(fx)
  );
  ball_steer_ctrl_pd_axis #(.FRAC(FRAC), .KP(KP), .KD(KD), .F_MAX_Q(F_MAX_Q)) u_pd_y (
    .clk(clk), .rst_n(rst_n), .en_i(pd_en), .first_i(first_q), .clr_i(pd_clr),
    .pos_i(mm16_t'(pos_mm_y_i)), .force_o(fy)
  );
  assign force_x_q_o = fx;
  assign force_y_q_o = fy;
  assign busy_o      = active;
  assign done_o      = done_q;
  assign timeout_o   = to_q;
  assign tick_cnt_o  = tick_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_ball_steer_ctrl.sv
// tb_ball_steer_ctrl: scenario tasks with a force scoreboard fed by an independent PD model.
module tb_ball_steer_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, clk_en = 1'b0, start_i = 1'b0, abort_i = 1'b0, goal = 1'b0;
  logic signed [15:0] pos_x = '0, pos_y = '0;
  logic signed [23:0] fx, fy;
  logic busy, done, tmo;
  logic [15:0] tick_cnt;
  logic [2:0] state;
  int total = 0, bad = 0;
  typedef struct { logic signed [23:0] fx; logic signed [23:0] fy; } exp_t;
  exp_t sb[$];
  longint m_px = 0, m_py = 0;
  bit m_first = 1'b0;

  ball_steer_ctrl #(.TIMEOUT_TICKS(32)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start_i(start_i), .abort_i(abort_i),
    .pos_mm_x_i(pos_x), .pos_mm_y_i(pos_y), .goal_reached_i(goal),
    .force_x_q_o(fx), .force_y_q_o(fy), .busy_o(busy), .done_o(done), .timeout_o(tmo),
    .tick_cnt_o(tick_cnt), .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic longint pd_model(longint e, longint prev, bit first);
    longint d, f;
    d = first ? 0 : e - prev;
    f = (64 * e + 256 * d) * 16;
    return f > 65536 ? 65536 : (f < -65536 ? -65536 : f);
  endfunction

  task automatic run_tick(input int px, input int py, input bit g, input bit zero);
    exp_t e, got;
    longint ex, ey;
    ex = -px;
    ey = -py;
    e.fx = zero ? '0 : 24'(pd_model(ex, m_px, m_first));
    e.fy = zero ? '0 : 24'(pd_model(ey, m_py, m_first));
    m_px = ex;
    m_py = ey;
    m_first = 1'b0;
    sb.push_back(e);
    pos_x = 16'(px);
    pos_y = 16'(py);
    goal = g;
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    got = sb.pop_front();
    total++;
    if (fx !== got.fx || fy !== got.fy) begin
      bad++;
      $display("FAIL force pos=(%0d,%0d): got (%0d,%0d) want (%0d,%0d)", px, py, fx, fy, got.fx, got.fy);
    end
  endtask

  task automatic start_ep();
    start_i = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    start_i = 1'b0;
    m_first = 1'b1;
    total++;
    if (state !== 3'd1 || busy !== 1'b1 || tick_cnt !== 16'd0) begin
      bad++;
      $display("FAIL start: state=%0d busy=%b tick=%0d want 1/1/0", state, busy, tick_cnt);
    end
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({fx, fy, busy, done, tmo, tick_cnt, state} !== '0) begin
      bad++;
      $display("FAIL reset: fx=%0d fy=%0d busy=%b done=%b to=%b tick=%0d st=%0d want all 0",
               fx, fy, busy, done, tmo, tick_cnt, state);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_pd();
    start_ep();
    run_tick(-10, 0, 1'b0, 1'b0);
    total++;
    if (fx !== 24'sd10240 || busy !== 1'b1) begin
      bad++;
      $display("FAIL first_force: fx=%0d busy=%b want 10240/1", fx, busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (fx !== 24'sd10240 || fy !== 24'sd0) begin
      bad++;
      $display("FAIL hold_between_ticks: fx=%0d fy=%0d want 10240/0", fx, fy);
    end
    run_tick(-8, 0, 1'b0, 1'b0);
    total++;
    if (fx !== 24'sd0) begin
      bad++;
      $display("FAIL deriv_cancel: fx=%0d want 0", fx);
    end
    run_tick(300, -300, 1'b0, 1'b0);
    total++;
    if (fx !== -24'sd65536 || fy !== 24'sd65536) begin
      bad++;
      $display("FAIL saturate: fx=%0d fy=%0d want -65536/65536", fx, fy);
    end
  endtask

  task automatic test_done();
    for (int i = 0; i < 16; i++) run_tick(i - 5, 3 - i, 1'b1, i == 15);
    total++;
    if (done !== 1'b1 || state !== 3'd3 || tick_cnt !== 16'd19 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: done=%b st=%0d tick=%0d busy=%b want 1/3/19/0", done, state, tick_cnt, busy);
    end
    @(posedge clk);
    #1;
    total++;
    if (done !== 1'b0 || state !== 3'd0 || fx !== 24'sd0 || fy !== 24'sd0) begin
      bad++;
      $display("FAIL done_to_idle: done=%b st=%0d fx=%0d fy=%0d want 0/0/0/0", done, state, fx, fy);
    end
  endtask

  task automatic test_hold_drop_abort();
    start_ep();
    for (int i = 0; i < 10; i++) run_tick(2, -1, 1'b1, 1'b0);
    total++;
    if (state !== 3'd2) begin
      bad++;
      $display("FAIL enter_hold: st=%0d want 2", state);
    end
    start_i = 1'b1;
    run_tick(4, 1, 1'b0, 1'b0);
    start_i = 1'b0;
    total++;
    if (state !== 3'd1 || tick_cnt !== 16'd11) begin
      bad++;
      $display("FAIL drop_start_ignored: st=%0d tick=%0d want 1/11", state, tick_cnt);
    end
    for (int i = 0; i < 15; i++) run_tick(i, -i, 1'b1, 1'b0);
    total++;
    if (state !== 3'd2 || done !== 1'b0 || tick_cnt !== 16'd26) begin
      bad++;
      $display("FAIL hold_cleared: st=%0d done=%b tick=%0d want 2/0/26", state, done, tick_cnt);
    end
    abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    total++;
    if (state !== 3'd0 || fx !== 24'sd0 || fy !== 24'sd0 || done !== 1'b0 || tmo !== 1'b0 || tick_cnt !== 16'd26) begin
      bad++;
      $display("FAIL abort: st=%0d fx=%0d fy=%0d done=%b to=%b tick=%0d want 0/0/0/0/0/26",
               state, fx, fy, done, tmo, tick_cnt);
    end
  endtask

  task automatic test_timeout();
    int px, py;
    start_ep();
    for (int i = 0; i < 32; i++) begin
      px = int'($urandom_range(0, 600)) - 300;
      py = int'($urandom_range(0, 600)) - 300;
      run_tick(px, py, 1'b0, i == 31);
      if (i == 30) begin
        total++;
        if (tmo !== 1'b0 || state !== 3'd1) begin
          bad++;
          $display("FAIL early_timeout: to=%b st=%0d want 0/1", tmo, state);
        end
      end
    end
    total++;
    if (tmo !== 1'b1 || state !== 3'd4 || tick_cnt !== 16'd32 || done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_pulse: to=%b st=%0d tick=%0d done=%b want 1/4/32/0", tmo, state, tick_cnt, done);
    end
    @(posedge clk);
    #1;
    total++;
    if (tmo !== 1'b0 || state !== 3'd0 || tick_cnt !== 16'd32) begin
      bad++;
      $display("FAIL timeout_to_idle: to=%b st=%0d tick=%0d want 0/0/32", tmo, state, tick_cnt);
    end
  endtask

  task automatic test_async_reset();
    start_ep();
    run_tick(-20, 40, 1'b0, 1'b0);
    run_tick(-20, 40, 1'b1, 1'b0);
    run_tick(-20, 40, 1'b1, 1'b0);
    total++;
    if (state !== 3'd2 || fx === 24'sd0) begin
      bad++;
      $display("FAIL pre_reset_hold: st=%0d fx=%0d want 2/nonzero", state, fx);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({fx, fy, busy, done, tmo, tick_cnt, state} !== '0) begin
      bad++;
      $display("FAIL async_reset: fx=%0d fy=%0d busy=%b st=%0d tick=%0d want all 0", fx, fy, busy, state, tick_cnt);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pd();
    test_done();
    test_hold_drop_abort();
    test_timeout();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
